// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the bit-serial adder-subtractor.
// The master drives operands and accepts results; the slave is the adder.
interface serial_addsub_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial signed/unsigned adder-subtractor, one bit per cycle, LSB first.
// Reports the unsigned carry and the two's-complement overflow of the result.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus,
    output logic [1:0]     state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and the payload is held while valid=1.
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             c_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             sum_d;
    logic             c_d;
    logic             last_bit;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    always_comb begin
        sum_d    = sa_q[0] ^ sb_q[0] ^ c_q;
        c_d      = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        res_d    = {sum_d, res_q[WIDTH-1:1]};
        // On the last bit the shift registers hold the latched MSBs of a and b'.
        ovf_d    = (sa_q[0] == sb_q[0]) && (sum_d != sa_q[0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            c_q         <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b ^ {WIDTH{bus.sub}};
                        c_q     <= bus.sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        carry_q     <= c_d;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vectors, backpressure,
// mid-operation reset and randomized back-to-back traffic against a reference.
`timescale 1ns/1ps
module tb_serial_addsub;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [WIDTH+1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    localparam logic [7:0] VA [4] = '{8'h7F, 8'h80, 8'h80, 8'h05};
    localparam logic [7:0] VB [4] = '{8'h01, 8'h80, 8'h01, 8'h07};
    localparam logic       VS [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [7:0] ER [4] = '{8'h80, 8'h00, 8'h7F, 8'hFE};
    localparam logic       EC [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic       EV [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reference: plain integer arithmetic in the unsigned and signed views.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic sub);
        int ua, ub, sa, sb, ur, sr;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur >= (1 << WIDTH));
        end
        v = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        return {c, v, ur[WIDTH-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sub, output logic ok, output int acc_cyc);
        int n;
        n = 0;
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 30) begin
            tick();
            n++;
        end
        ok = bus.in_ready;
        tick();
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        tests_run++;
        if (bus.result !== '0 || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got r=%h c=%b v=%b exp 00/0/0", bus.result, bus.carry, bus.overflow);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic_add();
        logic ok;
        int acc, lat;
        bus.out_ready = 1'b1;
        drive_accept(8'h64, 8'h1B, 1'b0, ok, acc);
        wait_out(lat);
        tests_run++;
        if (!ok || lat !== WIDTH) begin
            tests_failed++;
            $display("FAIL basic_latency got ok=%b lat=%0d exp 1/%0d", ok, lat, WIDTH);
        end
        tests_run++;
        if (bus.result !== 8'h7F || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_add got r=%h c=%b v=%b exp 7f/0/0", bus.result, bus.carry, bus.overflow);
        end
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_turnaround got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_vectors();
        logic ok;
        int acc, lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_accept(VA[i], VB[i], VS[i], ok, acc);
            wait_out(lat);
            tests_run++;
            if (!ok || lat !== WIDTH || bus.result !== ER[i] || bus.carry !== EC[i] ||
                bus.overflow !== EV[i]) begin
                tests_failed++;
                $display("FAIL vector_%0d got lat=%0d r=%h c=%b v=%b exp %0d/%h/%b/%b", i, lat,
                         bus.result, bus.carry, bus.overflow, WIDTH, ER[i], EC[i], EV[i]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic ok;
        int acc, lat;
        bus.out_ready = 1'b0;
        drive_accept(8'h7F, 8'h01, 1'b0, ok, acc);
        wait_out(lat);
        tests_run++;
        if (!ok || lat !== WIDTH || bus.result !== 8'h80 || bus.carry !== 1'b0 || bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_result got lat=%0d r=%h c=%b v=%b exp %0d/80/0/1", lat, bus.result,
                     bus.carry, bus.overflow, WIDTH);
        end
        for (int i = 0; i < 5; i++) begin
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            bus.sub = 1'($urandom_range(0, 1));
            bus.in_valid = ~bus.in_valid;
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 8'h80 ||
                bus.carry !== 1'b0 || bus.overflow !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d got ov=%b ir=%b r=%h c=%b v=%b exp 1/0/80/0/1", i,
                         bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.overflow);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        lat = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) lat++;
        end
        tests_run++;
        if (lat !== 0) begin
            tests_failed++;
            $display("FAIL bp_no_capture got %0d valid cycles exp 0", lat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic ok;
        int acc, lat, pulses;
        bus.out_ready = 1'b1;
        drive_accept(8'h7F, 8'h01, 1'b0, ok, acc);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_outputs got ov=%b r=%h c=%b v=%b ir=%b exp 0/00/0/0/1",
                     bus.out_valid, bus.result, bus.carry, bus.overflow, bus.in_ready);
        end
        pulses = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_valid got %0d pulses exp 0", pulses);
        end
        drive_accept(8'h10, 8'h20, 1'b0, ok, acc);
        wait_out(lat);
        tests_run++;
        if (!ok || lat !== WIDTH || bus.result !== 8'h30 || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_next_op got lat=%0d r=%h c=%b v=%b exp %0d/30/0/0", lat,
                     bus.result, bus.carry, bus.overflow, WIDTH);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic ok;
        int acc, prev_acc, lat;
        logic [WIDTH-1:0] a, b;
        logic sub;
        logic [WIDTH+1:0] e;
        bus.out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            sub = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, sub));
            drive_accept(a, b, sub, ok, acc);
            if (i > 0) begin
                tests_run++;
                if (acc - prev_acc !== WIDTH + 2) begin
                    tests_failed++;
                    $display("FAIL b2b_interval_%0d got %0d exp %0d", i, acc - prev_acc, WIDTH + 2);
                end
            end
            prev_acc = acc;
            wait_out(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || lat !== WIDTH || bus.result !== e[WIDTH-1:0] || bus.carry !== e[WIDTH+1] ||
                bus.overflow !== e[WIDTH]) begin
                tests_failed++;
                $display("FAIL b2b_op_%0d a=%h b=%h sub=%b got lat=%0d r=%h c=%b v=%b exp %0d/%h/%b/%b",
                         i, a, b, sub, lat, bus.result, bus.carry, bus.overflow, WIDTH,
                         e[WIDTH-1:0], e[WIDTH+1], e[WIDTH]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
